// File: rtl/float_byte_serializer.sv
`default_nettype none
// ============================================================================
// float_byte_serializer : buffers converter float words, emits them as bytes
// Rev 1.0
// ============================================================================
module float_byte_serializer #(
  parameter int FLOAT_WID = 80,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic [FLOAT_WID-1:0]   in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [7:0]             out_byte,
  output logic                   out_last,
  input  logic                   out_ready,
  input  logic                   clr_ovf,
  output logic                   overflow,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int NUM_BYTES = FLOAT_WID / 8;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int LVL_W     = PTR_W + 1;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [FLOAT_WID-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic                   overflow_q, overflow_d;
  logic [FLOAT_WID-1:0]   mem [DEPTH];

  logic w_full, w_push, w_drop, w_hs, w_last, w_pop;
  logic [FLOAT_WID-1:0] w_shifted;

  always_comb begin
    w_full  = (level_q == LVL_W'(DEPTH));
    w_push  = in_valid && !w_full;
    w_drop  = in_valid && w_full;
    w_hs    = (state_q == SEND) && out_ready;
    w_last  = (byte_cnt_q == CNT_W'(NUM_BYTES - 1));
    // Reload from the FIFO either when idle or right on the last-byte handshake
    w_pop   = (level_q != '0) && ((state_q == IDLE) || (w_hs && w_last));
    if (MSB_FIRST) w_shifted = {shift_q[FLOAT_WID-9:0], 8'h00};
    else           w_shifted = {8'h00, shift_q[FLOAT_WID-1:8]};

    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (w_pop) begin
      shift_d    = mem[rd_ptr_q];
      byte_cnt_d = '0;
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      state_d    = SEND;
    end else if (w_hs) begin
      shift_d    = w_shifted;
      byte_cnt_d = w_last ? '0 : byte_cnt_q + CNT_W'(1);
      if (w_last) state_d = IDLE;
    end

    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(w_push) - LVL_W'(w_pop);

    // A drop in the same cycle as a clear keeps the flag set
    if (w_drop)       overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
    else              overflow_d = overflow_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem[wr_ptr_q] <= in_data;
  end

  assign in_ready  = !w_full;
  assign out_valid = (state_q == SEND);
  assign out_byte  = (state_q != SEND) ? 8'h00 :
                     (MSB_FIRST ? shift_q[FLOAT_WID-1 -: 8] : shift_q[7:0]);
  assign out_last  = (state_q == SEND) && w_last;
  assign overflow  = overflow_q;
  assign busy      = (level_q != '0) || (state_q == SEND);
  assign level     = level_q;

endmodule
`default_nettype wire

// File: tb/tb_float_byte_serializer.sv
`default_nettype none
// ============================================================================
// tb_float_byte_serializer : directed self-checking bench for the serializer
// Rev 1.0
// ============================================================================
module tb_float_byte_serializer;

  logic        clk, rstn;
  logic        in_valid, in_ready, out_valid, out_last, out_ready, clr_ovf, overflow, busy;
  logic [79:0] in_data;
  logic [7:0]  out_byte;
  logic [2:0]  level;

  logic        in_valid_b, in_ready_b, out_valid_b, out_last_b, overflow_b, busy_b;
  logic [79:0] in_data_b;
  logic [7:0]  out_byte_b;
  logic [2:0]  level_b;

  int n_checks, n_fail;

  float_byte_serializer #(.FLOAT_WID(80), .DEPTH(4), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last), .out_ready(out_ready),
    .clr_ovf(clr_ovf), .overflow(overflow), .busy(busy), .level(level));

  float_byte_serializer #(.FLOAT_WID(80), .DEPTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_byte(out_byte_b), .out_last(out_last_b), .out_ready(1'b1),
    .clr_ovf(1'b0), .overflow(overflow_b), .busy(busy_b), .level(level_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_byte !== 8'h00) begin n_fail++; $display("FAIL reset_out_byte: got %h want 00", out_byte); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_busy: got %b%b want 00", overflow, busy); end
  endtask

  task automatic test_single_lsb();
    logic [7:0] exp [10];
    exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h3F};
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_data = 80'h3FFF8000000000000000;
    @(negedge clk); in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_latency: out_valid got %b want 0 one cycle after write", out_valid); end
    n_checks++; if (busy !== 1'b1 || level !== 3'd1) begin n_fail++; $display("FAIL lsb_busy_level: got busy=%b level=%0d want 1,1", busy, level); end
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_byte !== exp[i] || out_last !== (i == 9)) begin
        n_fail++; $display("FAIL lsb_byte%0d: got v=%b b=%h l=%b want v=1 b=%h l=%b", i, out_valid, out_byte, out_last, exp[i], (i == 9));
      end
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL lsb_end: got v=%b busy=%b want 0,0", out_valid, busy); end
  endtask

  task automatic test_single_msb();
    logic [7:0] exp [10];
    exp = '{8'h3F, 8'hFF, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    @(negedge clk); in_valid_b = 1'b1; in_data_b = 80'h3FFF8000000000000000;
    @(negedge clk); in_valid_b = 1'b0;
    n_checks++; if (out_valid_b !== 1'b0) begin n_fail++; $display("FAIL msb_latency: out_valid got %b want 0", out_valid_b); end
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid_b !== 1'b1 || out_byte_b !== exp[i] || out_last_b !== (i == 9)) begin
        n_fail++; $display("FAIL msb_byte%0d: got v=%b b=%h l=%b want v=1 b=%h l=%b", i, out_valid_b, out_byte_b, out_last_b, exp[i], (i == 9));
      end
      @(negedge clk);
    end
    n_checks++; if (out_valid_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL msb_end: got v=%b busy=%b want 0,0", out_valid_b, busy_b); end
  endtask

  task automatic test_backpressure();
    logic pat [4];
    int hs, cyc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    hs = 0; cyc = 0;
    @(negedge clk); in_valid = 1'b1; in_data = 80'h09080706050403020100;
    @(negedge clk); in_valid = 1'b0;
    while (hs < 10 && cyc < 100) begin
      out_ready = pat[cyc % 4];
      if (out_valid === 1'b1) begin
        n_checks++;
        if (out_byte !== 8'(hs) || out_last !== (hs == 9)) begin
          n_fail++; $display("FAIL bp_byte%0d: got b=%h l=%b want b=%h l=%b", hs, out_byte, out_last, 8'(hs), (hs == 9));
        end
        if (out_ready) hs++;
      end else if (hs > 0) begin
        n_checks++; n_fail++; $display("FAIL bp_valid_drop: out_valid got 0 want 1 after %0d handshakes", hs);
      end
      @(negedge clk); cyc++;
    end
    out_ready = 1'b1;
    n_checks++; if (hs != 10) begin n_fail++; $display("FAIL bp_count: got %0d handshakes want 10", hs); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_end: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [20];
    exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h3F,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'hFF, 8'hBF};
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_data = 80'h3FFF8000000000000000;
    @(negedge clk); in_data = 80'hBFFF8000000000000000;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_byte !== exp[i] || out_last !== (i == 9 || i == 19)) begin
        n_fail++; $display("FAIL b2b_byte%0d: got v=%b b=%h l=%b want v=1 b=%h l=%b", i, out_valid, out_byte, out_last, exp[i], (i == 9 || i == 19));
      end
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got v=%b busy=%b want 0,0", out_valid, busy); end
  endtask

  task automatic test_overflow();
    int hs, cyc, idle_valid;
    logic [7:0] e;
    out_ready = 1'b0;
    // Word k: byte0 = k, byte9 = A0+k. The first word sits in the shift register, four fill the FIFO.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 5) begin
        n_checks++; if (level !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_full: got level=%0d in_ready=%b want 4,0", level, in_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0 before drop", overflow); end
      end
      in_valid = 1'b1; in_data = {8'hA0 + 8'(k), 64'h0, 8'(k)};
    end
    @(negedge clk); in_valid = 1'b1; in_data = 80'hEEEE; clr_ovf = 1'b1;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    @(negedge clk); in_valid = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    @(negedge clk); clr_ovf = 1'b0;
    n_checks++; if (overflow !== 1'b0 || level !== 3'd4) begin n_fail++; $display("FAIL ovf_clear: got ovf=%b level=%0d want 0,4", overflow, level); end
    out_ready = 1'b1;
    hs = 0; cyc = 0;
    while (hs < 50 && cyc < 200) begin
      if (out_valid === 1'b1) begin
        if (hs % 10 == 0)      e = 8'(hs / 10);
        else if (hs % 10 == 9) e = 8'hA0 + 8'(hs / 10);
        else                   e = 8'h00;
        n_checks++;
        if (out_byte !== e || out_last !== (hs % 10 == 9)) begin
          n_fail++; $display("FAIL ovf_drain%0d: got b=%h l=%b want b=%h l=%b", hs, out_byte, out_last, e, (hs % 10 == 9));
        end
        hs++;
      end
      @(negedge clk); cyc++;
    end
    idle_valid = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) idle_valid++;
      @(negedge clk);
    end
    n_checks++; if (hs != 50 || idle_valid != 0) begin n_fail++; $display("FAIL ovf_word_count: got %0d bytes + %0d extra want 50 + 0", hs, idle_valid); end
  endtask

  task automatic test_reset_mid();
    int hs, cyc, late;
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_data = 80'h09080706050403020100;
    @(negedge clk); in_data = 80'h13121110;
    @(negedge clk); in_valid = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 3 && cyc < 20) begin
      if (out_valid === 1'b1) hs++;
      @(negedge clk); cyc++;
    end
    n_checks++; if (hs != 3) begin n_fail++; $display("FAIL rst_pre: got %0d handshakes want 3", hs); end
    rstn = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || level !== 3'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got v=%b level=%0d busy=%b want 0,0,0", out_valid, level, busy);
    end
    @(negedge clk); rstn = 1'b1;
    late = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) late++;
    end
    n_checks++; if (late != 0) begin n_fail++; $display("FAIL rst_quiet: got %0d active cycles want 0", late); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_ovf = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_lsb();
    test_single_msb();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
